// File: rtl/mem_arbiter_if.sv
// Bus bundle between the requesters, the round-robin memory arbiter and the
// memory_mod access unit. The slave modport is the arbiter's view. The master
// modport is the environment's view: the requesters plus the memory unit.
interface mem_arbiter_if #(
  parameter int NREQ = 2
);
  // Requester side
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_wr;
  logic [8*NREQ-1:0]    req_addr;
  logic [16*NREQ-1:0]   req_wdata;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      ack;
  logic [15:0]          rdata;
  logic                 err;
  logic                 busy;

  // Memory unit side
  logic                 mem_start;
  logic                 mem_wr;
  logic [7:0]           mem_addr;
  logic [15:0]          mem_wdata;
  logic [15:0]          mem_rdata;
  logic                 mem_done;

  modport slave (
    input  req, req_wr, req_addr, req_wdata, mem_rdata, mem_done,
    output gnt, ack, rdata, err, busy, mem_start, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output req, req_wr, req_addr, req_wdata, mem_rdata, mem_done,
    input  gnt, ack, rdata, err, busy, mem_start, mem_wr, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory_mod access unit between NREQ
// requesters. Each access runs IDLE -> WAIT -> RELEASE. The RELEASE cycle
// forces mem_start low so the memory unit's cycle counter clears before the
// next access starts.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT cycles without mem_done. An aborted access gets ack together with
// err. When the macro is undefined, err is tied low.
module mem_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int IW = (NREQ > 2) ? 2 : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t             state_q;
  logic [IW-1:0]      last_q;
  logic [NREQ-1:0]    gnt_q;
  logic [NREQ-1:0]    ack_q;
  logic [15:0]        rdata_q;
  logic               busy_q;
  logic               memStart_q;
  logic               memWr_q;
  logic [7:0]         memAddr_q;
  logic [15:0]        memWdata_q;

  logic [IW-1:0]      pick_d;
  logic               pickValid_d;
  int                 cand;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0]         tmo_q;
  logic               err_q;
`endif

  // Round-robin search: first requester with req high, starting after the last owner
  always_comb begin
    pick_d      = last_q;
    pickValid_d = 1'b0;
    cand        = 0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = (int'(last_q) + k) % NREQ;
      if (!pickValid_d && bus.req[cand]) begin
        pick_d      = IW'(cand);
        pickValid_d = 1'b1;
      end
    end
  end

  // Access sequencer: every output is a register written only here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= IW'(NREQ - 1);
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      memStart_q <= 1'b0;
      memWr_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      tmo_q      <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (pickValid_d) begin
            gnt_q      <= NREQ'(1) << pick_d;
            last_q     <= pick_d;
            memWr_q    <= bus.req_wr[pick_d];
            memAddr_q  <= bus.req_addr[pick_d*8 +: 8];
            memWdata_q <= bus.req_wdata[pick_d*16 +: 16];
            memStart_q <= 1'b1;
            busy_q     <= 1'b1;
`ifdef MEM_ARB_TIMEOUT_EN
            tmo_q      <= '0;
`endif
            state_q    <= WAIT;
          end
        end

        WAIT: begin
          // Command fields stay frozen; last_q identifies the owner.
          if (bus.mem_done) begin
            ack_q      <= NREQ'(1) << last_q;
            if (!memWr_q) begin
              rdata_q  <= bus.mem_rdata;
            end
            memStart_q <= 1'b0;
            gnt_q      <= '0;
            state_q    <= RELEASE;
          end
`ifdef MEM_ARB_TIMEOUT_EN
          // The counter reads TIMEOUT-1 in the TIMEOUT-th WAIT cycle. A
          // mem_done in that same cycle takes the branch above instead.
          else if (tmo_q == 8'(TIMEOUT - 1)) begin
            ack_q      <= NREQ'(1) << last_q;
            err_q      <= 1'b1;
            memStart_q <= 1'b0;
            gnt_q      <= '0;
            state_q    <= RELEASE;
          end else begin
            tmo_q      <= tmo_q + 8'd1;
          end
`endif
        end

        RELEASE: begin
          ack_q   <= '0;
          busy_q  <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
          err_q   <= 1'b0;
`endif
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.ack       = ack_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.mem_start = memStart_q;
  assign bus.mem_wr    = memWr_q;
  assign bus.mem_addr  = memAddr_q;
  assign bus.mem_wdata = memWdata_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign bus.err       = err_q;
`else
  assign bus.err       = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with NREQ=2. A behavioural memory_mod model
// raises done 4 edges after it first sees start, and clears when start drops.
// Expected values are hand-computed from the access timeline:
// grant at E, ack visible after E+5, idle again after E+6.
module tb_mem_arbiter;

  localparam int NREQ = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  bit   holdDone = 1'b0;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  mem_arbiter_if #(.NREQ(NREQ)) bus ();

  mem_arbiter #(.NREQ(NREQ), .TIMEOUT(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Behavioural memory_mod: done and the memory operation occur on the 4th edge with start high
  initial begin : memModel
    logic [15:0] mem [256];
    int cnt;
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
    mem[8'h12] = 16'hBEEF;
    cnt = 0;
    bus.mem_done  <= 1'b0;
    bus.mem_rdata <= '0;
    forever begin
      @(posedge clk);
      if (!bus.mem_start) begin
        cnt = 0;
        bus.mem_done <= 1'b0;
      end else begin
        if (cnt == 3 && !holdDone) begin
          if (bus.mem_wr) mem[bus.mem_addr] = bus.mem_wdata;
          bus.mem_rdata <= mem[bus.mem_addr];
          bus.mem_done  <= 1'b1;
        end
        if (cnt < 255) cnt++;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic wr, input logic [7:0] addr,
                               input logic [15:0] wdata);
    bus.req_wr[idx]             = wr;
    bus.req_addr[idx*8 +: 8]    = addr;
    bus.req_wdata[idx*16 +: 16] = wdata;
    bus.req[idx]                = 1'b1;
  endtask

  task automatic waitGrant(input string tag, input logic [NREQ-1:0] expGnt,
                           input int expCycles);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (bus.gnt == '0 && n < 20);
    checkOutput({tag, "_grant_latency"}, n, expCycles);
    checkOutput({tag, "_gnt"}, 32'(bus.gnt), 32'(expGnt));
    checkOutput({tag, "_start"}, 32'(bus.mem_start), 32'd1);
    checkOutput({tag, "_busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic waitAck(input string tag, input int expCycles, input logic [NREQ-1:0] expAck,
                         input logic [15:0] expRdata, input logic expErr);
    int n;
    n = 0;
    while (bus.ack == '0 && n < 40) begin
      step();
      n++;
    end
    checkOutput({tag, "_ack_latency"}, n, expCycles);
    checkOutput({tag, "_ack"}, 32'(bus.ack), 32'(expAck));
    checkOutput({tag, "_rdata"}, 32'(bus.rdata), 32'(expRdata));
    checkOutput({tag, "_err"}, 32'(bus.err), 32'(expErr));
    checkOutput({tag, "_start_low"}, 32'(bus.mem_start), 32'd0);
    checkOutput({tag, "_gnt_low"}, 32'(bus.gnt), 32'd0);
  endtask

  initial begin : stimulus
    logic [NREQ-1:0] expGnt;
    bus.req       = '0;
    bus.req_wr    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset values
    step();
    step();
    checkOutput("rst_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_start", 32'(bus.mem_start), 32'd0);
    checkOutput("rst_rdata", 32'(bus.rdata), 32'd0);
    checkOutput("rst_addr", 32'(bus.mem_addr), 32'd0);
    rst_n = 1'b1;

    // Single read: requester 0 wins first
    applyStimulus(0, 1'b0, 8'h12, 16'h0000);
    waitGrant("rd1", 2'b01, 1);
    checkOutput("rd1_addr", 32'(bus.mem_addr), 32'h12);
    checkOutput("rd1_wr", 32'(bus.mem_wr), 32'd0);
    waitAck("rd1", 5, 2'b01, 16'hBEEF, 1'b0);
    bus.req[0] = 1'b0;
    step();
    checkOutput("rd1_ack_pulse", 32'(bus.ack), 32'd0);
    checkOutput("rd1_idle", 32'(bus.busy), 32'd0);

    // Write by requester 1, then read back by requester 0
    applyStimulus(1, 1'b1, 8'h40, 16'h1234);
    waitGrant("wr", 2'b10, 1);
    checkOutput("wr_memwr", 32'(bus.mem_wr), 32'd1);
    checkOutput("wr_wdata", 32'(bus.mem_wdata), 32'h1234);
    waitAck("wr", 5, 2'b10, 16'hBEEF, 1'b0);
    bus.req[1] = 1'b0;
    step();
    applyStimulus(0, 1'b0, 8'h40, 16'h0000);
    waitGrant("rb", 2'b01, 1);
    waitAck("rb", 5, 2'b01, 16'h1234, 1'b0);
    bus.req[0] = 1'b0;
    step();

    // Contention: both held high; last owner was 0 so order is 1,0,1,0
    applyStimulus(0, 1'b0, 8'h40, 16'h0000);
    applyStimulus(1, 1'b0, 8'h41, 16'h0000);
    expGnt = 2'b10;
    for (int g = 0; g < 4; g++) begin
      waitGrant($sformatf("rr%0d", g), expGnt, 1);
      waitAck($sformatf("rr%0d", g), 5, expGnt,
              (expGnt == 2'b01) ? 16'h1234 : 16'hA541, 1'b0);
      step();
      checkOutput($sformatf("rr%0d_gap", g), 32'(bus.mem_start), 32'd0);
      expGnt = ~expGnt;
    end
    bus.req = '0;
    step();

    // Async reset during WAIT
    applyStimulus(0, 1'b0, 8'h05, 16'h0000);
    waitGrant("ar", 2'b01, 1);
    step();
    step();
    #1 rst_n = 1'b0;
    #1;
    checkOutput("ar_start", 32'(bus.mem_start), 32'd0);
    checkOutput("ar_gnt", 32'(bus.gnt), 32'd0);
    checkOutput("ar_busy", 32'(bus.busy), 32'd0);
    checkOutput("ar_rdata", 32'(bus.rdata), 32'd0);
    step();
    rst_n = 1'b1;
    waitGrant("ar_re", 2'b01, 1);
    checkOutput("ar_re_addr", 32'(bus.mem_addr), 32'h05);
    waitAck("ar_re", 5, 2'b01, 16'hA505, 1'b0);
    bus.req[0] = 1'b0;
    step();

    // Late request from 1 during 0's WAIT
    applyStimulus(0, 1'b0, 8'h12, 16'h0000);
    waitGrant("late0", 2'b01, 1);
    step();
    step();
    applyStimulus(1, 1'b0, 8'h41, 16'h0000);
    step();
    checkOutput("late0_addr_held", 32'(bus.mem_addr), 32'h12);
    checkOutput("late0_gnt_held", 32'(bus.gnt), 32'b01);
    waitAck("late0", 2, 2'b01, 16'hBEEF, 1'b0);
    bus.req[0] = 1'b0;
    step();
    waitGrant("late1", 2'b10, 1);
    checkOutput("late1_addr", 32'(bus.mem_addr), 32'h41);
    waitAck("late1", 5, 2'b10, 16'hA541, 1'b0);
    bus.req[1] = 1'b0;
    step();

`ifdef MEM_ARB_TIMEOUT_EN
    // Timeout: done withheld, abort 15 cycles after WAIT entry
    holdDone = 1'b1;
    applyStimulus(0, 1'b0, 8'h12, 16'h0000);
    waitGrant("tmo", 2'b01, 1);
    waitAck("tmo", 15, 2'b01, 16'hA541, 1'b1);
    bus.req[0] = 1'b0;
    holdDone = 1'b0;
    step();
    checkOutput("tmo_err_pulse", 32'(bus.err), 32'd0);
    applyStimulus(1, 1'b0, 8'h40, 16'h0000);
    waitGrant("tmo_next", 2'b10, 1);
    waitAck("tmo_next", 5, 2'b10, 16'h1234, 1'b0);
    bus.req[1] = 1'b0;
    step();
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
